// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin RAM arbiter (mem_arbiter).
// Lock-related types are only used when MEM_ARB_LOCK_EN is defined.
package mem_arb_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef logic [1:0] master_idx_t;

  typedef struct packed {
    logic        valid;
    master_idx_t idx;
  } rd_tag_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder. The search starts at
// last_winner+1 and wraps; it returns a one-hot grant plus the winner index.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  master_idx_t            last_winner,
  output logic [NUM_MASTERS-1:0] gnt,
  output master_idx_t            win_idx,
  output logic                   any_gnt
);

  // Outer loop walks the priority offsets; inner loop finds the master at that offset.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    any_gnt = 1'b0;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (!any_gnt && req[m] && (m == (int'(last_winner) + 1 + off) % NUM_MASTERS)) begin
          any_gnt = 1'b1;
          gnt[m]  = 1'b1;
          win_idx = master_idx_t'(m);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port word RAM between masters,
// with tagged read return. Define MEM_ARB_LOCK_EN to add the m_lock_i bus lock.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 15,
  parameter int RD_LATENCY  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_i,
  input  logic [NUM_MASTERS-1:0]                 m_req_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]     m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]     m_wdata_i,
  input  logic [NUM_MASTERS-1:0][MASK_W-1:0]     m_wmask_i,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]                 m_lock_i,
`endif
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  output logic [DATA_W-1:0]                      m_rdata_o,
  output logic                                   mem_sel_o,
  output logic                                   mem_we_o,
  output logic [ADDR_W-1:0]                      mem_addr_o,
  output logic [DATA_W-1:0]                      mem_wdata_o,
  output logic [MASK_W-1:0]                      mem_wmask_o,
  input  logic [DATA_W-1:0]                      mem_rdata_i
);

  master_idx_t            last_winner_reg;
  master_idx_t            last_winner_next;
  logic [NUM_MASTERS-1:0] req_eff;
  logic [NUM_MASTERS-1:0] pick_gnt;
  master_idx_t            pick_idx;
  logic                   pick_any;
  rd_tag_t                new_tag;
  rd_tag_t                tail_tag;

  rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req         (req_eff),
    .last_winner (last_winner_reg),
    .gnt         (pick_gnt),
    .win_idx     (pick_idx),
    .any_gnt     (pick_any)
  );

`ifdef MEM_ARB_LOCK_EN
  lock_state_t            lock_state_reg;
  lock_state_t            lock_state_next;
  master_idx_t            lock_owner_reg;
  master_idx_t            lock_owner_next;
  logic [NUM_MASTERS-1:0] owner_mask;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   win_lock;
  logic                   idle_release;

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      owner_mask[i] = (lock_owner_reg == master_idx_t'(i));
    end
  end

  assign owner_req  = |(m_req_i & owner_mask);
  assign owner_lock = |(m_lock_i & owner_mask);
  assign win_lock   = |(m_lock_i & pick_gnt);

  // While locked the picker only ever sees the owner's request.
  assign req_eff = m_req_i & {NUM_MASTERS{reset_i}} &
                   ((lock_state_reg == LOCKED) ? owner_mask : {NUM_MASTERS{1'b1}});

  always_comb begin
    lock_state_next = lock_state_reg;
    lock_owner_next = lock_owner_reg;
    idle_release    = 1'b0;
    case (lock_state_reg)
      UNLOCKED: begin
        if (pick_any && win_lock) begin
          lock_state_next = LOCKED;
          lock_owner_next = pick_idx;
        end
      end
      LOCKED: begin
        if (pick_any) begin
          if (!win_lock) lock_state_next = UNLOCKED;
        end else if (!owner_req && !owner_lock) begin
          lock_state_next = UNLOCKED;
          idle_release    = 1'b1;
        end
      end
      default: lock_state_next = UNLOCKED;
    endcase

    if (pick_any)          last_winner_next = pick_idx;
    else if (idle_release) last_winner_next = lock_owner_reg;
    else                   last_winner_next = last_winner_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      lock_state_reg <= UNLOCKED;
      lock_owner_reg <= '0;
    end else begin
      lock_state_reg <= lock_state_next;
      lock_owner_reg <= lock_owner_next;
    end
  end
`else
  assign req_eff = m_req_i & {NUM_MASTERS{reset_i}};

  always_comb begin
    last_winner_next = pick_any ? pick_idx : last_winner_reg;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_i) last_winner_reg <= master_idx_t'(NUM_MASTERS - 1);
    else          last_winner_reg <= last_winner_next;
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt[i]) begin
        mem_we_o    = m_we_i[i];
        mem_addr_o  = m_addr_i[i];
        mem_wdata_o = m_wdata_i[i];
        mem_wmask_o = m_wmask_i[i];
      end
    end
  end

  assign mem_sel_o = pick_any;
  assign m_gnt_o   = pick_gnt;

  always_comb begin
    new_tag.valid = pick_any & ~mem_we_o;
    new_tag.idx   = pick_idx;
  end

  // Read-tag shift register, one stage per cycle of RAM read latency.
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
    rd_tag_t tag_reg;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!reset_i) tag_reg <= '0;
        else          tag_reg <= new_tag;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (!reset_i) tag_reg <= '0;
        else          tag_reg <= g_tag[gi-1].tag_reg;
      end
    end
  end

  assign tail_tag = g_tag[RD_LATENCY-1].tag_reg;

  // Gated by reset so a read in flight when reset drops never surfaces.
  always_comb begin
    m_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid_o[i] = reset_i & tail_tag.valid & (tail_tag.idx == master_idx_t'(i));
    end
  end

  assign m_rdata_o = mem_rdata_i;

endmodule
